// File: rtl/test_axis_rx_chk.sv
// Receive-side checker for AXIS Ethernet test frames.
// Parses the dst/src/length header, checks the incrementing repeated-byte
// payload, beat count and final tkeep, and keeps per-frame pulses, saturating
// frame/error counters and sticky error flags.
//
// FSM states
//   state  | meaning
//   S_HDR  | header beats (dst, src, length, first pattern byte)
//   S_PAY  | payload beats, byte pattern and tkeep checked
//   S_DROP | error already seen in this frame; swallow beats until tlast
module test_axis_rx_chk #(
    parameter int          AXIS_DATA_WIDTH = 64,
    parameter int          FRAME_BEATS     = 130,
    parameter logic [47:0] EXP_DST_ADDR    = 48'ha1a1a1a1a1a1,
    parameter logic [47:0] EXP_SRC_ADDR    = 48'ha0a0a0a0a0a0,
    parameter logic [15:0] EXP_LEN         = 16'd512
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         chk_en,
    input  logic                         bp_en,
    input  logic                         clr_stat,
    input  logic [AXIS_DATA_WIDTH-1:0]   rx_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] rx_axis_tkeep,
    input  logic                         rx_axis_tvalid,
    input  logic                         rx_axis_tlast,
    output logic                         rx_axis_tready,
    output logic                         frame_done,
    output logic                         frame_ok,
    output logic [15:0]                  frame_cnt,
    output logic [15:0]                  err_cnt,
    output logic [5:0]                   err_flags
);

    localparam int W         = AXIS_DATA_WIDTH;
    localparam int KW        = W / 8;
    localparam int HDR_BEATS = (W == 64) ? 2 : 4;
    localparam int CW        = $clog2(FRAME_BEATS + 1);

    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_BEATS - 1);
    localparam logic [CW-1:0] HDR_LAST = CW'(HDR_BEATS - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BEATS);

    // Last beat carries the pattern in all lanes but the top two.
    localparam logic [KW-1:0] KEEP_ALL  = {KW{1'b1}};
    localparam logic [KW-1:0] KEEP_LAST = {2'b00, {(KW-2){1'b1}}};

    localparam int F_DST  = 0;
    localparam int F_SRC  = 1;
    localparam int F_LEN  = 2;
    localparam int F_PAY  = 3;
    localparam int F_CNT  = 4;
    localparam int F_KEEP = 5;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PAY  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            toggle_q;
    logic [CW-1:0]   beat_cnt_q;
    logic [7:0]      exp_pat_q;
    logic            frame_err_q;

    logic            beat;
    logic            at_last_idx;
    logic            frame_end;
    logic            frame_bad;
    logic [5:0]      err_now;
    logic            pay_bad;
    logic [7:0]      exp_next;
    logic [KW-1:0]   lane_mask;
    logic [7:0]      pat_hi;
    logic [7:0]      pat_lo;

    // Header field views: which beat completes each field and its assembled value.
    logic            hdr_dst_chk;
    logic            hdr_src_chk;
    logic            hdr_len_chk;
    logic [47:0]     hdr_dst_val;
    logic [47:0]     hdr_src_val;
    logic [15:0]     hdr_len_val;

    assign beat        = rx_axis_tvalid & rx_axis_tready;
    assign at_last_idx = (beat_cnt_q == LAST_IDX);
    assign frame_end   = beat & rx_axis_tlast;
    assign frame_bad   = frame_err_q | (|err_now);
    assign pat_hi      = rx_axis_tdata[W-1 -: 8];
    assign pat_lo      = rx_axis_tdata[W-9 -: 8];
    assign exp_next    = exp_pat_q + 8'd1;

    generate
        if (W == 64) begin : g_w64
            logic [15:0] src_lo_q;

            // Low 16 bits of src ride in the top of beat 0.
            always_ff @(posedge clk) begin
                if (rst) begin
                    src_lo_q <= '0;
                end else if (beat && state_q == S_HDR && beat_cnt_q == CW'(0)) begin
                    src_lo_q <= rx_axis_tdata[63:48];
                end
            end

            assign hdr_dst_chk = (beat_cnt_q == CW'(0));
            assign hdr_dst_val = rx_axis_tdata[47:0];
            assign hdr_src_chk = (beat_cnt_q == CW'(1));
            assign hdr_src_val = {rx_axis_tdata[31:0], src_lo_q};
            assign hdr_len_chk = (beat_cnt_q == CW'(1));
            assign hdr_len_val = rx_axis_tdata[47:32];
        end else if (W == 32) begin : g_w32
            logic [31:0] dst_lo_q;
            logic [15:0] src_lo_q;

            // Fields straddle beats 0..2; keep the early pieces until complete.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dst_lo_q <= '0;
                    src_lo_q <= '0;
                end else if (beat && state_q == S_HDR) begin
                    if (beat_cnt_q == CW'(0)) dst_lo_q <= rx_axis_tdata;
                    if (beat_cnt_q == CW'(1)) src_lo_q <= rx_axis_tdata[31:16];
                end
            end

            assign hdr_dst_chk = (beat_cnt_q == CW'(1));
            assign hdr_dst_val = {rx_axis_tdata[15:0], dst_lo_q};
            assign hdr_src_chk = (beat_cnt_q == CW'(2));
            assign hdr_src_val = {rx_axis_tdata[31:0], src_lo_q};
            assign hdr_len_chk = (beat_cnt_q == CW'(3));
            assign hdr_len_val = rx_axis_tdata[15:0];
        end else begin : g_bad_width
            $error("test_axis_rx_chk: AXIS_DATA_WIDTH must be 64 or 32");
        end
    endgenerate

    // Per-beat error detection; nothing is reported once the frame is being dropped.
    always_comb begin
        err_now   = '0;
        pay_bad   = 1'b0;
        lane_mask = at_last_idx ? (rx_axis_tkeep & KEEP_LAST) : rx_axis_tkeep;
        for (int i = 0; i < KW; i++) begin
            if (lane_mask[i] && rx_axis_tdata[8*i +: 8] != exp_next) begin
                pay_bad = 1'b1;
            end
        end
        if (beat && state_q != S_DROP) begin
            err_now[F_CNT]  = rx_axis_tlast ? !at_last_idx : at_last_idx;
            err_now[F_KEEP] = (rx_axis_tkeep != (at_last_idx ? KEEP_LAST : KEEP_ALL));
            if (state_q == S_HDR) begin
                err_now[F_DST] = hdr_dst_chk && (hdr_dst_val != EXP_DST_ADDR);
                err_now[F_SRC] = hdr_src_chk && (hdr_src_val != EXP_SRC_ADDR);
                err_now[F_LEN] = hdr_len_chk && (hdr_len_val != EXP_LEN);
                // Both pattern bytes of the last header beat must agree.
                err_now[F_PAY] = (beat_cnt_q == HDR_LAST) && (pat_hi != pat_lo);
            end else begin
                err_now[F_PAY] = pay_bad;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: any tlast returns to S_HDR; the first error diverts to S_DROP.
    always_comb begin
        state_d = state_q;
        if (beat) begin
            case (state_q)
                S_HDR: begin
                    if (rx_axis_tlast)            state_d = S_HDR;
                    else if (|err_now)            state_d = S_DROP;
                    else if (beat_cnt_q == HDR_LAST) state_d = S_PAY;
                end
                S_PAY: begin
                    if (rx_axis_tlast)            state_d = S_HDR;
                    else if (|err_now)            state_d = S_DROP;
                end
                S_DROP: begin
                    if (rx_axis_tlast)            state_d = S_HDR;
                end
                default: state_d = S_HDR;
            endcase
        end
    end

    // Registered tready; toggle free-runs so backpressure alternates every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_q       <= 1'b0;
            rx_axis_tready <= 1'b0;
        end else begin
            toggle_q       <= ~toggle_q;
            rx_axis_tready <= chk_en & (~bp_en | toggle_q);
        end
    end

    // Beat counter, expected pattern byte and per-frame error memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            exp_pat_q   <= '0;
            frame_err_q <= 1'b0;
        end else if (beat) begin
            if (rx_axis_tlast) begin
                beat_cnt_q  <= '0;
                frame_err_q <= 1'b0;
            end else begin
                if (beat_cnt_q != CNT_SAT) beat_cnt_q <= beat_cnt_q + CW'(1);
                frame_err_q <= frame_bad;
            end
            if (state_q == S_HDR && beat_cnt_q == HDR_LAST) begin
                exp_pat_q <= pat_lo;
            end else if (state_q == S_PAY) begin
                exp_pat_q <= exp_next;
            end
        end
    end

    // Frame pulses, saturating counters and sticky flags; clr_stat wins over updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
            err_flags  <= '0;
        end else begin
            frame_done <= frame_end;
            frame_ok   <= frame_end & ~frame_bad;
            if (clr_stat) begin
                frame_cnt <= '0;
                err_cnt   <= '0;
                err_flags <= '0;
            end else begin
                err_flags <= err_flags | err_now;
                if (frame_end && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
                if (frame_end && frame_bad && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule
